// File: rtl/seq_1011_tx.sv
// Serial frame transmitter: sync marker 1011, payload MSB-first, zero gap.
// Optional trailing even-parity bit when SEQ_1011_TX_PARITY_EN is defined.
module seq_1011_tx #(
    parameter int DATA_W  = 8,
    parameter int GAP_LEN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out,
    output logic              busy,
    output logic              frame_done
);

    localparam int MAXC_DG = (DATA_W > GAP_LEN) ? DATA_W : GAP_LEN;
    localparam int MAXC    = (MAXC_DG > 4) ? MAXC_DG : 4;
    localparam int CW      = $clog2(MAXC + 1);

    localparam logic [CW-1:0] LAST_S = CW'(3);
    localparam logic [CW-1:0] LAST_D = CW'(DATA_W - 1);
    localparam logic [CW-1:0] LAST_G = CW'(GAP_LEN - 1);

`ifdef SEQ_1011_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
`ifdef SEQ_1011_TX_PARITY_EN
        PAR,
`endif
        GAP
    } state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [DATA_W-1:0] sreg, sreg_d;
    logic              out_d, done_d, busy_d;
    logic              take;
`ifdef SEQ_1011_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    // The last gap cycle also accepts a word so frames abut after GAP_LEN zeros.
    assign in_ready = !rst && ((state == IDLE) ||
                               ((state == GAP) && (cnt == LAST_G)));
    assign take     = in_valid && in_ready;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        sreg_d  = sreg;
        out_d   = 1'b0;
        done_d  = 1'b0;
`ifdef SEQ_1011_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state)
            IDLE: begin
            end
            SYNC: begin
                if (cnt == LAST_S) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    out_d   = sreg[DATA_W-1];
                    done_d  = !PAR_EN && (DATA_W == 1);
                end else begin
                    cnt_d = cnt + 1'b1;
                    out_d = (cnt != '0);
                end
            end
            DATA: begin
                if (cnt == LAST_D) begin
`ifdef SEQ_1011_TX_PARITY_EN
                    state_d = PAR;
                    out_d   = par_q;
                    done_d  = 1'b1;
`else
                    state_d = GAP;
`endif
                    cnt_d = '0;
                end else begin
                    cnt_d  = cnt + 1'b1;
                    sreg_d = sreg << 1;
                    out_d  = sreg_d[DATA_W-1];
                    done_d = !PAR_EN && (cnt_d == LAST_D);
                end
            end
`ifdef SEQ_1011_TX_PARITY_EN
            PAR: begin
                state_d = GAP;
                cnt_d   = '0;
            end
`endif
            GAP: begin
                if (cnt == LAST_G) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (take) begin
            state_d = SYNC;
            cnt_d   = '0;
            sreg_d  = in_data;
            out_d   = 1'b1;
            done_d  = 1'b0;
`ifdef SEQ_1011_TX_PARITY_EN
            par_d   = ^in_data;
`endif
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sreg       <= '0;
            out        <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef SEQ_1011_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            sreg       <= sreg_d;
            out        <= out_d;
            busy       <= busy_d;
            frame_done <= done_d;
`ifdef SEQ_1011_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_1011_tx.sv
// Directed bench for seq_1011_tx with a loopback 1011 detector.
module tb_seq_1011_tx;

`ifdef SEQ_1011_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FL = 14 + P;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_ready, out, busy, frame_done;

    int passed = 0;
    int total  = 0;

    logic [2:0] hist = 3'b000;
    logic       det  = 1'b0;

    logic [FL-1:0]   fbits;
    logic [2*FL-1:0] sbits;
    int bcnt, fdpos, fdcnt, xf, tx1, tx2, bsum, dcnt, d1, d2;
    logic fire;

    always #5 clk = ~clk;

    seq_1011_tx #(.DATA_W(8), .GAP_LEN(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out        (out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Receiver-side detector fed by the serial stream
    always @(posedge clk) begin
        hist <= {hist[1:0], out};
        det  <= ({hist, out} == 4'b1011);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FL-1:0] mk_frame(input logic [7:0] d);
`ifdef SEQ_1011_TX_PARITY_EN
        return {4'b1011, d, ^d, 2'b00};
`else
        return {4'b1011, d, 2'b00};
`endif
    endfunction

    task automatic frame(input logic [7:0] d, output logic [FL-1:0] bits,
                         output int bc, output int fp, output int fc);
        bits = '0; bc = 0; fp = 0; fc = 0;
        in_valid = 1'b1;
        in_data  = d;
        tick;
        in_valid = 1'b0;
        in_data  = ~d;
        for (int i = 1; i <= FL; i++) begin
            bits[FL-i] = out;
            if (busy) bc++;
            if (frame_done) begin
                fp = i;
                fc++;
            end
            tick;
        end
    endtask

    initial begin
        // 1: reset, single A5 frame
        rst = 1'b1;
        tick; tick; tick;
        chk("rst_out", out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", in_ready, 1);
        frame(8'hA5, fbits, bcnt, fdpos, fdcnt);
        chk("t1_stream", fbits, mk_frame(8'hA5));
`ifndef SEQ_1011_TX_PARITY_EN
        chk("t1_literal", fbits, 14'b1011_10100101_00);
`endif
        chk("t1_busy", bcnt, FL);
        chk("t1_done_pos", fdpos, 12 + P);
        chk("t1_done_cnt", fdcnt, 1);
        chk("t1_ready_end", in_ready, 1);
        chk("t1_busy_end", busy, 0);

        // 2: in_valid held, FF then 00
        xf = 0; tx1 = -1; tx2 = -1; bsum = 0; sbits = '0;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int t = 0; t <= 2*FL + 1; t++) begin
            if (t >= 1 && t <= 2*FL) begin
                sbits[2*FL-t] = out;
                if (busy) bsum++;
            end
            fire = in_valid && in_ready;
            if (fire) begin
                xf++;
                if (xf == 1) tx1 = t;
                if (xf == 2) tx2 = t;
            end
            tick;
            if (fire && xf == 1) in_data = 8'h00;
            if (fire && xf == 2) in_valid = 1'b0;
        end
        chk("t2_stream", sbits, {mk_frame(8'hFF), mk_frame(8'h00)});
        chk("t2_xfers", xf, 2);
        chk("t2_spacing", tx2 - tx1, FL);
        chk("t2_busy", bsum, 2*FL);

        // 3: in_valid pulses while not ready
        xf = 0;
        fbits = '0;
        in_valid = 1'b1;
        in_data  = 8'h69;
        tick;
        in_valid = 1'b0;
        for (int i = 1; i <= FL; i++) begin
            if (i == 2 || i == 7 || i == 13) begin
                in_valid = 1'b1;
                in_data  = 8'h3C;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            fbits[FL-i] = out;
            if (in_valid && in_ready) xf++;
            tick;
        end
        in_valid = 1'b0;
        chk("t3_stream", fbits, mk_frame(8'h69));
        chk("t3_xfers", xf, 0);
        chk("t3_ready", in_ready, 1);
        chk("t3_idle_busy", busy, 0);

        // 4: reset in cycle 6 of a C3 frame
        fdcnt = 0;
        in_valid = 1'b1;
        in_data  = 8'hC3;
        tick;
        in_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (frame_done) fdcnt++;
            tick;
        end
        chk("t4_busy_mid", busy, 1);
        if (frame_done) fdcnt++;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        chk("t4_out", out, 0);
        chk("t4_busy", busy, 0);
        chk("t4_ready", in_ready, 1);
        for (int i = 0; i < 10; i++) begin
            if (frame_done) fdcnt++;
            tick;
        end
        chk("t4_no_done", fdcnt, 0);
        chk("t4_quiet_out", out, 0);
        frame(8'h81, fbits, bcnt, fdpos, fdcnt);
        chk("t4_stream", fbits, mk_frame(8'h81));
        chk("t4_done_cnt", fdcnt, 1);

`ifdef SEQ_1011_TX_PARITY_EN
        // 5: parity bit and frame length
        frame(8'hA5, fbits, bcnt, fdpos, fdcnt);
        chk("t5_par_a5", fbits[2], 0);
        chk("t5_len_a5", bcnt, 15);
        chk("t5_done_a5", fdpos, 13);
        frame(8'h01, fbits, bcnt, fdpos, fdcnt);
        chk("t5_par_01", fbits[2], 1);
        chk("t5_len_01", bcnt, 15);
        chk("t5_done_01", fdpos, 13);
`endif

        // 6: loopback into detector, payload 00
        xf = 0; dcnt = 0; d1 = -1; d2 = -1;
        in_valid = 1'b1;
        in_data  = 8'h00;
        for (int t = 0; t <= 2*FL + 1; t++) begin
            if (t >= 1 && det) begin
                dcnt++;
                if (dcnt == 1) d1 = t;
                if (dcnt == 2) d2 = t;
            end
            fire = in_valid && in_ready;
            if (fire) xf++;
            tick;
            if (fire && xf == 2) in_valid = 1'b0;
        end
        chk("t6_det_cnt", dcnt, 2);
        chk("t6_det_first", d1, 5);
        chk("t6_det_second", d2, 5 + FL);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
